// File: rtl/lenet_fifo_reader.sv
// Circular buffer between the LeNet conv engine and its consumer: strobed writes in,
// first-word fall-through valid/ready stream out, with frame-end marking and sticky error.
module lenet_fifo_reader #(
    parameter int IMAGE_PIXEL_WIDTH  = 8,
    parameter int KERNEL_PIXEL_WIDTH = 8,
    parameter int FIFO_DEPTH         = 9,
    localparam int DW = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH,
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          fifo_in,
    input  logic [DW-1:0] data_out,
    input  logic          done,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [CW-1:0] count,
    output logic          frame_done,
    output logic          err
);

    localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    logic [DW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_last_pend;
    logic [PW-1:0] r_last_idx;
    logic          r_wr_since_last;
    logic          r_err;
    logic          r_frame_done;

    logic          w_wr_acc;
    logic          w_rd_fire;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_prev_idx;
    logic [PW-1:0] w_done_idx;
    logic          w_empty_done;

    assign fifo_full  = (r_count == FULL_CNT);
    assign fifo_empty = (r_count == '0);
    assign count      = r_count;
    assign err        = r_err;
    assign frame_done = r_frame_done;

    assign rd_valid = !fifo_empty;
    assign rd_data  = rd_valid ? r_mem[r_rptr] : '0;
    assign rd_last  = rd_valid && r_last_pend && (r_rptr == r_last_idx);

    // Full decision uses the registered count; a same-cycle read never frees the slot.
    assign w_wr_acc  = fifo_in && !fifo_full;
    assign w_rd_fire = rd_valid && rd_ready;

    assign w_wptr_nxt = (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
    assign w_rptr_nxt = (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
    assign w_prev_idx = (r_wptr == '0) ? LAST_PTR : r_wptr - PW'(1);
    assign w_done_idx = w_wr_acc ? r_wptr : w_prev_idx;

    assign w_empty_done = done && !r_last_pend && !r_wr_since_last && !w_wr_acc;

    always_ff @(posedge clock) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= data_out;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_last_pend     <= 1'b0;
            r_last_idx      <= '0;
            r_wr_since_last <= 1'b0;
            r_err           <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= w_wptr_nxt;
            end
            if (w_rd_fire) begin
                r_rptr <= w_rptr_nxt;
            end

            case ({w_wr_acc, w_rd_fire})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (fifo_in && fifo_full) begin
                r_err <= 1'b1;
            end

            // A done that arrives while a last is still pending is dropped as a protocol error.
            if (done) begin
                r_wr_since_last <= 1'b0;
                if (r_last_pend) begin
                    r_err <= 1'b1;
                end else if (r_wr_since_last || w_wr_acc) begin
                    r_last_pend <= 1'b1;
                    r_last_idx  <= w_done_idx;
                end
            end else if (w_wr_acc) begin
                r_wr_since_last <= 1'b1;
            end

            if (w_rd_fire && rd_last) begin
                r_last_pend <= 1'b0;
            end

            r_frame_done <= (w_rd_fire && rd_last) || w_empty_done;
        end
    end

endmodule

// File: tb/tb_lenet_fifo_reader.sv
// Scoreboard bench for lenet_fifo_reader: stimulus pushes expected elements, a negedge
// monitor pops and compares on every read fire and checks frame_done timing.
module tb_lenet_fifo_reader;

    localparam int DEPTH = 9;
    localparam int DW    = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_in = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          done = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] count;
    logic          frame_done;
    logic          err;

    lenet_fifo_reader #(
        .IMAGE_PIXEL_WIDTH (8),
        .KERNEL_PIXEL_WIDTH(8),
        .FIFO_DEPTH        (DEPTH)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .fifo_in   (fifo_in),
        .data_out  (data_out),
        .done      (done),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .count     (count),
        .frame_done(frame_done),
        .err       (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } ent_t;

    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_count = 0;
    bit   m_err = 0;
    bit   m_pend = 0;
    bit   m_wsl = 0;
    bit   empty_done = 0;
    bit   exp_fd = 0;
    int   fd_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change at posedge+1, so negedge sees the values used at the next edge.
    always @(negedge clock) begin
        ent_t e;
        if (!rst_n) begin
            exp_fd     = 1'b0;
            empty_done = 1'b0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(exp_fd));
            if (frame_done) fd_pulses++;
            exp_fd     = empty_done;
            empty_done = 1'b0;
            if (!rd_valid) begin
                chk("rd_data_gated", 32'(rd_data), 32'h0);
                chk("rd_last_gated", 32'(rd_last), 32'h0);
            end else if (rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got %0h expected no read", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_data", 32'(rd_data), 32'(e.d));
                    chk("rd_last", 32'(rd_last), 32'(e.l));
                    if (e.l) begin
                        m_pend = 1'b0;
                        exp_fd = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_rd_last", 32'(rd_last), 32'h0);
        chk("rst_full", 32'(fifo_full), 32'h0);
        chk("rst_empty", 32'(fifo_empty), 32'h1);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
    endtask

    task automatic do_reset();
        fifo_in  = 1'b0;
        done     = 1'b0;
        rd_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        m_count = 0;
        m_err   = 1'b0;
        m_pend  = 1'b0;
        m_wsl   = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock of stimulus: check current state against the model, then issue ops.
    task automatic cyc(input bit wr, input logic [DW-1:0] d, input bit rd, input bit dn);
        bit   acc;
        bit   fire;
        bit   p0;
        ent_t e;
        chk("count", 32'(count), 32'(m_count));
        chk("fifo_full", 32'(fifo_full), 32'(m_count == DEPTH));
        chk("fifo_empty", 32'(fifo_empty), 32'(m_count == 0));
        chk("rd_valid", 32'(rd_valid), 32'(m_count > 0));
        chk("err", 32'(err), 32'(m_err));
        acc = wr && (m_count < DEPTH);
        fire = rd && (m_count > 0);
        p0 = m_pend;
        if (wr && !acc) m_err = 1'b1;
        if (dn) begin
            if (p0) begin
                m_err = 1'b1;
            end else if (m_wsl || acc) begin
                m_pend = 1'b1;
                if (!acc && exp_q.size() > 0) begin
                    e = exp_q[exp_q.size() - 1];
                    e.l = 1'b1;
                    exp_q[exp_q.size() - 1] = e;
                end
            end else begin
                empty_done = 1'b1;
            end
            m_wsl = 1'b0;
        end else if (acc) begin
            m_wsl = 1'b1;
        end
        if (acc) begin
            e.d = d;
            e.l = dn && !p0;
            exp_q.push_back(e);
        end
        m_count = m_count + int'(acc) - int'(fire);
        fifo_in  = wr;
        data_out = d;
        rd_ready = rd;
        done     = dn;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int sent;
        int fd0;
        do_reset();

        // Fill to full, overflow, then drain in order.
        for (int i = 1; i <= 9; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        chk("full_after_9", 32'(fifo_full), 32'h1);
        chk("count_after_9", 32'(count), 32'd9);
        cyc(1'b1, DW'(10), 1'b0, 1'b0);
        chk("err_overflow", 32'(err), 32'h1);
        for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("empty_after_drain", 32'(fifo_empty), 32'h1);

        // Wrap-around streaming with alternating consumer ready.
        do_reset();
        sent = 0;
        for (int c = 0; c < 200; c++) begin
            if (sent >= 25 && m_count == 0) break;
            if (sent < 25 && m_count < DEPTH) begin
                cyc(1'b1, DW'(16'h100 + sent), (c % 2) == 0, 1'b0);
                sent++;
            end else begin
                cyc(1'b0, '0, (c % 2) == 0, 1'b0);
            end
        end
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("wrap_all_drained", 32'(exp_q.size()), 32'h0);
        chk("wrap_err", 32'(err), 32'h0);

        // Concurrent read and write at count 3.
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h200 + i), 1'b0, 1'b0);
        for (int i = 3; i < 8; i++) cyc(1'b1, DW'(16'h200 + i), 1'b1, 1'b0);
        chk("concurrent_count", 32'(count), 32'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // Frame marking, then an empty frame.
        fd0 = fd_pulses;
        for (int i = 0; i < 3; i++) cyc(1'b1, DW'(16'h300 + i), 1'b0, 1'b0);
        cyc(1'b1, DW'(16'h303), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("frame_pulses", 32'(fd_pulses - fd0), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("empty_frame_pulses", 32'(fd_pulses - fd0), 32'd2);

        // Second done while a last is pending.
        for (int i = 0; i < 2; i++) cyc(1'b1, DW'(16'h400 + i), 1'b0, 1'b0);
        cyc(1'b1, DW'(16'h402), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("err_double_done", 32'(err), 32'h1);
        cyc(1'b1, DW'(16'h403), 1'b0, 1'b0);
        cyc(1'b1, DW'(16'h404), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        chk("double_done_pulses", 32'(fd_pulses - fd0), 32'd3);

        // Reset with count 5 and a pending last, then a fresh write.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, DW'(16'h500 + i), 1'b0, 1'b0);
        cyc(1'b1, DW'(16'h504), 1'b0, 1'b1);
        chk("pre_reset_count", 32'(count), 32'd5);
        chk("pre_reset_last", 32'(rd_last), 32'h0);
        do_reset();
        cyc(1'b1, DW'(16'h00AB), 1'b0, 1'b0);
        chk("post_reset_data", 32'(rd_data), 32'hAB);
        chk("post_reset_last", 32'(rd_last), 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
